mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, word address width of the shared data RAM.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter RD_LAT, default 1, RAM read latency in cycles; legal range 1-4.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 cpu_req, cpu_we  input  1 each  CPU data-port request and write select (1=write).
REQ-007 cpu_addr  input  ADDR_W; cpu_wdata  input  DATA_W  CPU request payload.
REQ-008 cpu_vld  output  1; cpu_rdata  output  DATA_W  CPU completion pulse and read data.
REQ-009 img_req, img_we, img_addr, img_wdata, img_vld, img_rdata  same directions and widths as the CPU port, for the image processor.
REQ-010 spart_req  input  1; spart_addr  input  ADDR_W; spart_vld  output  1; spart_rdata  output  DATA_W  read-only SPART port.
REQ-011 mem_en, mem_we  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  RAM command.
REQ-012 mem_rdata  input  DATA_W  RAM read data, valid RD_LAT cycles after the mem_en cycle.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 grant  output  2  requester currently served: 0=CPU, 1=IMG, 2=SPART.

Function
REQ-015 Requester indices: 0=CPU, 1=IMG, 2=SPART; SPART requests are always reads.
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one transaction is in flight at a time.
REQ-017 IDLE: if any req is high, select the winner, latch its index into grant, latch its addr/we/wdata, and go to ISSUE; otherwise stay in IDLE.
REQ-018 Round-robin arbitration: search order starts at (last_grant+1) mod 3; last_grant updates only when a winner is selected.
REQ-019 ISSUE: mem_en=1 for exactly one cycle with the latched addr, we and wdata; go to DONE if write, WAIT if read.
REQ-020 WAIT: counter loads RD_LAT-1 on entry and stays exactly RD_LAT cycles; mem_rdata is sampled in the last WAIT cycle into the granted requester's rdata register; then go to DONE.
REQ-021 DONE: pulse the granted requester's vld for exactly one cycle, then go to IDLE.
REQ-022 Latency from req sampled in IDLE: write vld 2 cycles later; read vld 2+RD_LAT cycles later.
REQ-023 rdata of each port holds its value until that port's next read completes; writes do not alter rdata.
REQ-024 mem_en, mem_we, mem_addr and mem_wdata are 0 in every non-ISSUE cycle.
REQ-025 Requester handshake: hold req and payload until vld; a req still high in the IDLE cycle after vld counts as a new request.
REQ-026 A req dropped mid-transaction is ignored; the transaction completes and vld still pulses.
REQ-027 Payload changes after the IDLE latch cycle have no effect on the in-flight transaction.
REQ-028 Never pulse more than one vld in the same cycle; never pulse vld outside DONE.
REQ-029 An unserved requester waits at most 2 other transactions before it is granted.

Reset
REQ-030 While rst=1 at a rising edge: FSM goes to IDLE; last_grant=2 so the CPU wins first; grant=0; busy=0; all vld=0; all rdata=0; mem_* outputs=0.
REQ-031 rst asserted mid-transaction aborts it: no vld is produced, and mem_en=0 from the next cycle.

Verification
REQ-032 CPU write: cpu_req=1, cpu_we=1, addr=0x010, wdata=0xDEADBEEF -> mem_en=1, mem_we=1 one cycle later, cpu_vld 2 cycles after the req was sampled.
REQ-033 CPU read with RD_LAT=1, RAM returning 0xDEADBEEF -> cpu_vld 3 cycles after the req was sampled, cpu_rdata=0xDEADBEEF, then held.
REQ-034 All three reqs held high after reset -> grant sequence 0,1,2,0,1,2; each vld pulses once per transaction.
REQ-035 Reset asserted in WAIT with RD_LAT=4 -> no img_vld, busy=0 and mem_en=0 the cycle after the rst edge.
REQ-036 SPART and IMG requesting while the CPU requests back-to-back -> each is granted within 2 CPU transactions; payload changes after the latch cycle do not alter mem_addr.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-port round-robin arbiter for a shared single-port data RAM
// One transaction in flight at a time: IDLE -> ISSUE -> (WAIT x RD_LAT) -> DONE.
module mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_vld,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              img_req,
  input  logic              img_we,
  input  logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_wdata,
  output logic              img_vld,
  output logic [DATA_W-1:0] img_rdata,
  input  logic              spart_req,
  input  logic [ADDR_W-1:0] spart_addr,
  output logic              spart_vld,
  output logic [DATA_W-1:0] spart_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        grant
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  logic [1:0]        r_state;
  logic [1:0]        r_grant;
  logic [1:0]        r_last;
  logic [1:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_img_rdata;
  logic [DATA_W-1:0] r_spart_rdata;

  logic [2:0]        w_req;
  logic              w_any;
  logic [1:0]        w_win;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_issue;
  logic              w_done;

  assign w_req = {spart_req, img_req, cpu_req};
  assign w_any = |w_req;

  // Search starts one past the last winner, wrapping 2 -> 0.
  always_comb begin
    w_win = 2'd0;
    case (r_last)
      2'd0:    w_win = w_req[1] ? 2'd1 : (w_req[2] ? 2'd2 : 2'd0);
      2'd1:    w_win = w_req[2] ? 2'd2 : (w_req[0] ? 2'd0 : 2'd1);
      default: w_win = w_req[0] ? 2'd0 : (w_req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = spart_addr;
    w_win_wdata = '0;
    case (w_win)
      2'd0: begin
        w_win_we    = cpu_we;
        w_win_addr  = cpu_addr;
        w_win_wdata = cpu_wdata;
      end
      2'd1: begin
        w_win_we    = img_we;
        w_win_addr  = img_addr;
        w_win_wdata = img_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant       <= 2'd0;
      r_last        <= 2'd2;
      r_cnt         <= 2'd0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cpu_rdata   <= '0;
      r_img_rdata   <= '0;
      r_spart_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_last  <= w_win;
            r_we    <= w_win_we;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= CNT_INIT;
          r_state <= r_we ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            case (r_grant)
              2'd0:    r_cpu_rdata   <= mem_rdata;
              2'd1:    r_img_rdata   <= mem_rdata;
              default: r_spart_rdata <= mem_rdata;
            endcase
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_issue   = (r_state == S_ISSUE);
  assign w_done    = (r_state == S_DONE);
  assign mem_en    = w_issue;
  assign mem_we    = w_issue & r_we;
  assign mem_addr  = w_issue ? r_addr : '0;
  assign mem_wdata = w_issue ? r_wdata : '0;

  assign cpu_vld     = w_done && (r_grant == 2'd0);
  assign img_vld     = w_done && (r_grant == 2'd1);
  assign spart_vld   = w_done && (r_grant == 2'd2);
  assign cpu_rdata   = r_cpu_rdata;
  assign img_rdata   = r_img_rdata;
  assign spart_rdata = r_spart_rdata;
  assign busy        = (r_state != S_IDLE);
  assign grant       = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [2:0]    req = '0;
  logic [2:0]    we  = '0;
  logic [AW-1:0] addr [3];
  logic [DW-1:0] wdata [3];
  logic [2:0]    vld;
  logic [DW-1:0] rdata [3];
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    grant;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
    .cpu_vld(vld[0]), .cpu_rdata(rdata[0]),
    .img_req(req[1]), .img_we(we[1]), .img_addr(addr[1]), .img_wdata(wdata[1]),
    .img_vld(vld[1]), .img_rdata(rdata[1]),
    .spart_req(req[2]), .spart_addr(addr[2]), .spart_vld(vld[2]), .spart_rdata(rdata[2]),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
  );

  // Second instance with the slowest legal RAM, used for latency and abort checks
  logic          b_rst = 1'b1;
  logic          b_img_req = 1'b0;
  logic [AW-1:0] b_img_addr = '0;
  logic          b_cpu_vld, b_img_vld, b_spart_vld, b_mem_en, b_mem_we, b_busy;
  logic [DW-1:0] b_cpu_rdata, b_img_rdata, b_spart_rdata, b_mem_wdata;
  logic [AW-1:0] b_mem_addr;
  logic [1:0]    b_grant;
  logic [DW-1:0] b_pipe [4];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(4)) u_dut4 (
    .clk(clk), .rst(b_rst),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr('0), .cpu_wdata('0),
    .cpu_vld(b_cpu_vld), .cpu_rdata(b_cpu_rdata),
    .img_req(b_img_req), .img_we(1'b0), .img_addr(b_img_addr), .img_wdata('0),
    .img_vld(b_img_vld), .img_rdata(b_img_rdata),
    .spart_req(1'b0), .spart_addr('0), .spart_vld(b_spart_vld), .spart_rdata(b_spart_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_pipe[3]), .busy(b_busy), .grant(b_grant)
  );

  // RAMs drive data only in the cycle it is due, zero otherwise
  function automatic logic [DW-1:0] dflt(input logic [4:0] a);
    return {16'hA5A5, 3'b000, a, 3'b000, a};
  endfunction

  logic [DW-1:0] ram [32];
  logic [31:0]   ram_v = '0;

  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? (ram_v[mem_addr[4:0]] ? ram[mem_addr[4:0]] : dflt(mem_addr[4:0])) : '0;
    if (mem_en && mem_we) begin
      ram[mem_addr[4:0]]   <= mem_wdata;
      ram_v[mem_addr[4:0]] <= 1'b1;
    end
    b_pipe[0] <= (b_mem_en && !b_mem_we) ? (32'hC0DE_0000 | 32'(b_mem_addr)) : '0;
    for (int i = 1; i < 4; i++) b_pipe[i] <= b_pipe[i-1];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: cycle index, timestamps of the one in-flight transaction
  int            n = 0;
  int            m_free = 0, m_issue = -1, m_vldc = -1, m_g = 0, m_last = 2;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_pend = '0;
  logic [DW-1:0] m_rd [3];
  logic [DW-1:0] m_mem [32];
  bit            churn_en = 1'b0;

  function automatic int rr_pick(input int last, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int p;
      p = (last + k) % 3;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_sample();
    int p;
    int lat;
    if (n < m_free) return;
    p = rr_pick(m_last, req);
    if (p < 0) return;
    m_g     = p;
    m_last  = p;
    m_we    = (p != 2) && we[p];
    m_addr  = addr[p];
    m_wdata = (p == 2) ? '0 : wdata[p];
    lat     = m_we ? 0 : 1;
    m_issue = n + 1;
    m_vldc  = n + 2 + lat;
    m_free  = n + 3 + lat;
    if (m_we) m_mem[m_addr[4:0]] = m_wdata;
    else      m_pend = m_mem[m_addr[4:0]];
  endtask

  task automatic compare_all();
    check("busy",      64'(busy),      64'(n < m_free));
    check("mem_en",    64'(mem_en),    64'(n == m_issue));
    check("mem_we",    64'(mem_we),    64'((n == m_issue) && m_we));
    check("mem_addr",  64'(mem_addr),  64'((n == m_issue) ? m_addr : '0));
    check("mem_wdata", 64'(mem_wdata), 64'((n == m_issue) ? m_wdata : '0));
    check("grant",     64'(grant),     64'(m_g));
    for (int p = 0; p < 3; p++) begin
      check($sformatf("vld%0d", p),   64'(vld[p]),   64'((n == m_vldc) && (m_g == p)));
      check($sformatf("rdata%0d", p), 64'(rdata[p]), 64'(m_rd[p]));
    end
  endtask

  task automatic new_payload(input int p);
    addr[p]  = AW'($urandom_range(0, 31));
    wdata[p] = $urandom;
    we[p]    = (p != 2) && ($urandom_range(0, 1) == 1);
  endtask

  // Payload of the granted port is scrambled right after the latch to prove it is not re-read
  task automatic tick();
    model_sample();
    @(posedge clk);
    n++;
    #1;
    if (churn_en && n == m_issue) begin
      addr[m_g]  = AW'($urandom_range(0, 16383));
      wdata[m_g] = $urandom;
      if (m_g != 2) we[m_g] = ~we[m_g];
      if ($urandom_range(0, 3) == 0) req[m_g] = 1'b0;
    end
    #1;
    if (n == m_vldc && !m_we) m_rd[m_g] = m_pend;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    n++;
    #2;
    m_free = n; m_issue = -1; m_vldc = -1; m_g = 0; m_last = 2;
    for (int p = 0; p < 3; p++) m_rd[p] = '0;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    int seq[$];
    int cpu_cnt, img_wait, sp_wait, k;
    bit img_done, sp_done, seen;

    for (int i = 0; i < 32; i++) m_mem[i] = dflt(5'(i));
    for (int p = 0; p < 3; p++) begin
      addr[p] = '0; wdata[p] = '0; m_rd[p] = '0;
    end

    // Reset state
    do_reset();
    check("rst_busy",  64'(busy),     64'(0));
    check("rst_grant", 64'(grant),    64'(0));
    check("rst_vld",   64'(vld),      64'(0));
    check("rst_rdata", 64'(rdata[0]), 64'(0));

    // CPU write then read back through the RD_LAT=1 RAM
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 14'h010; wdata[0] = 32'hDEAD_BEEF;
    tick();
    check("wr_mem_en", 64'(mem_en),   64'(1));
    check("wr_mem_we", 64'(mem_we),   64'(1));
    tick();
    check("wr_vld_at_2", 64'(vld[0]), 64'(1));
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1; we[0] = 1'b0;
    tick();
    tick();
    check("rd_no_vld_at_2", 64'(vld[0]), 64'(0));
    tick();
    check("rd_vld_at_3", 64'(vld[0]),   64'(1));
    check("rd_data",     64'(rdata[0]), 64'(32'hDEAD_BEEF));
    req[0] = 1'b0;
    repeat (3) tick();
    check("rd_data_held", 64'(rdata[0]), 64'(32'hDEAD_BEEF));

    // All three held high from reset: strict rotation starting at the CPU
    do_reset();
    req = 3'b111; we = 3'b000;
    addr[0] = 14'd1; addr[1] = 14'd2; addr[2] = 14'd3;
    repeat (24) begin
      tick();
      for (int p = 0; p < 3; p++) if (vld[p]) seq.push_back(p);
    end
    check("rr_count", 64'(seq.size()), 64'(6));
    for (int i = 0; i < 6 && i < seq.size(); i++)
      check($sformatf("rr_seq%0d", i), 64'(seq[i]), 64'(i % 3));
    req = '0;
    repeat (2) tick();

    // CPU back-to-back while IMG and SPART wait; payloads scrambled after latch
    churn_en = 1'b1;
    req[0] = 1'b1; new_payload(0);
    tick();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 14'd5;
    req[2] = 1'b1; addr[2] = 14'd7;
    cpu_cnt = 0; img_wait = 99; sp_wait = 99; img_done = 0; sp_done = 0;
    for (int c = 0; c < 60 && !(img_done && sp_done); c++) begin
      tick();
      if (vld[0]) begin cpu_cnt++; new_payload(0); end
      req[0] = 1'b1;
      if (vld[1]) begin img_done = 1; img_wait = cpu_cnt; req[1] = 1'b0; end
      if (vld[2]) begin sp_done = 1; sp_wait = cpu_cnt; req[2] = 1'b0; end
    end
    check("fair_img_done", 64'(img_done), 64'(1));
    check("fair_sp_done",  64'(sp_done),  64'(1));
    check("fair_img_wait", 64'(img_wait <= 2), 64'(1));
    check("fair_sp_wait",  64'(sp_wait <= 2),  64'(1));
    req = '0;
    repeat (8) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int p = 0; p < 3; p++) begin
        if (n == m_vldc && m_g == p) begin
          if ($urandom_range(0, 1) == 1) begin req[p] = 1'b1; new_payload(p); end
          else req[p] = 1'b0;
        end else if (!req[p] && $urandom_range(0, 2) == 0) begin
          req[p] = 1'b1;
          new_payload(p);
        end
      end
    end
    req = '0;
    repeat (8) tick();

    // RD_LAT=4: read latency, then reset while in WAIT
    @(posedge clk); #2;
    b_rst = 1'b0;
    b_img_req = 1'b1; b_img_addr = 14'h123;
    k = 0;
    for (int c = 1; c <= 12 && k == 0; c++) begin
      @(posedge clk); #2;
      if (b_img_vld) k = c;
    end
    check("lat4_cycles", 64'(k), 64'(6));
    check("lat4_rdata",  64'(b_img_rdata), 64'(32'hC0DE_0123));
    b_img_req = 1'b0;
    @(posedge clk); #2;
    b_img_req = 1'b1; b_img_addr = 14'h055;
    repeat (3) begin @(posedge clk); #2; end
    check("abort_pre_busy", 64'(b_busy), 64'(1));
    b_rst = 1'b1; b_img_req = 1'b0;
    @(posedge clk); #2;
    check("abort_busy",   64'(b_busy),   64'(0));
    check("abort_mem_en", 64'(b_mem_en), 64'(0));
    check("abort_vld",    64'({b_cpu_vld, b_img_vld, b_spart_vld}), 64'(0));
    check("abort_mem",    64'({b_mem_addr, b_mem_wdata}), 64'(0));
    check("abort_rdata",  64'(b_img_rdata | b_cpu_rdata | b_spart_rdata), 64'(0));
    check("abort_grant",  64'(b_grant), 64'(0));
    b_rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #2;
      if (b_img_vld || b_mem_en) seen = 1;
    end
    check("abort_quiet", 64'(seen), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
